// File: rtl/display_controller.sv
// display_controller: 8-bit to 4-digit seven-segment converter with double-dabble FSM and digit scan
module display_controller #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic       busy,
  output logic [7:0] segments,
  output logic [3:0] digit
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [69:0] FONT = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  function automatic logic [6:0] font(input logic [3:0] d);
    return FONT[7*d +: 7];
  endfunction
  function automatic logic [3:0] nib(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
  logic [1:0] state_q, state_d;
  logic neg_q, neg_d;
  logic [7:0] mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d, adj;
  logic [2:0] cnt_q, cnt_d;
  logic pend_v_q, pend_v_d, pend_sgn_q, pend_sgn_d;
  logic [7:0] pend_val_q, pend_val_d;
  logic [3:0][6:0] glyph_q, glyph_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] src_val;
  logic src_neg, start, tc;
  // In COMMIT a same-cycle load is newer than the slot, so it wins.
  assign src_val = (state_q == COMMIT && !load) ? pend_val_q : value;
  assign src_neg = ((state_q == COMMIT && !load) ? pend_sgn_q : signed_mode) & src_val[7];
  assign start = (state_q == IDLE && load) || (state_q == COMMIT && (load || pend_v_q));
  assign adj = {nib(bcd_q[11:8]), nib(bcd_q[7:4]), nib(bcd_q[3:0])};
  assign tc = presc_q == PW'(SCAN_DIV - 1);
  assign busy = state_q != IDLE;
  assign digit = 4'b0001 << idx_q;
  assign segments = {1'b1, ~glyph_q[idx_q]};
  always_comb begin
    state_d = state_q;
    neg_d = neg_q;
    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    pend_v_d = pend_v_q;
    pend_val_d = pend_val_q;
    pend_sgn_d = pend_sgn_q;
    glyph_d = glyph_q;
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d = tc ? idx_q + 2'd1 : idx_q;
    if (state_q == SHIFT) begin
      {bcd_d, mag_d} = {adj, mag_q} << 1;
      cnt_d = cnt_q + 3'd1;
      state_d = cnt_q == 3'd7 ? COMMIT : SHIFT;
      if (load) {pend_v_d, pend_val_d, pend_sgn_d} = {1'b1, value, signed_mode};
    end
    if (state_q == COMMIT) begin
      glyph_d = {neg_q ? 7'h40 : 7'h00,
                 bcd_q[11:8] == 4'd0 ? 7'h00 : font(bcd_q[11:8]),
                 bcd_q[11:4] == 8'd0 ? 7'h00 : font(bcd_q[7:4]),
                 font(bcd_q[3:0])};
      pend_v_d = 1'b0;
      state_d = IDLE;
    end
    if (start) begin
      state_d = SHIFT;
      neg_d = src_neg;
      mag_d = src_neg ? ~src_val + 8'd1 : src_val;
      bcd_d = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      neg_q <= 1'b0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      pend_v_q <= 1'b0;
      pend_val_q <= '0;
      pend_sgn_q <= 1'b0;
      glyph_q <= {7'h00, 7'h00, 7'h00, 7'h3F};
      presc_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      neg_q <= neg_d;
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_val_q <= pend_val_d;
      pend_sgn_q <= pend_sgn_d;
      glyph_q <= glyph_d;
      presc_q <= presc_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_display_controller.sv
// tb_display_controller: scoreboard bench for display_controller with SCAN_DIV=4
module tb_display_controller;
  logic sys_clk = 1'b0, rst = 1'b1, load = 1'b0, signed_mode = 1'b0;
  logic [7:0] value = '0;
  logic busy;
  logic [7:0] segments;
  logic [3:0] digit;
  int total = 0, bad = 0;
  logic [31:0] sb[$];
  display_controller #(.SCAN_DIV(4)) dut (
    .sys_clk(sys_clk), .rst(rst), .load(load), .value(value), .signed_mode(signed_mode),
    .busy(busy), .segments(segments), .digit(digit)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction
  // Packed as {digit3, digit2, digit1, digit0}, active-low segment bytes.
  function automatic logic [31:0] exp_disp(input logic [7:0] v, input logic s);
    logic neg;
    int m, h, t, o;
    neg = s & v[7];
    m = neg ? 256 - int'(v) : int'(v);
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    return {neg ? 8'hBF : 8'hFF, h == 0 ? 8'hFF : seg_of(h),
            (h == 0 && t == 0) ? 8'hFF : seg_of(t), seg_of(o)};
  endfunction
  function automatic int cur_idx();
    for (int i = 0; i < 4; i++) if (digit == (4'b0001 << i)) return i;
    return -1;
  endfunction
  task automatic read_disp(output logic [31:0] d);
    logic [3:0] seen;
    int i;
    seen = '0;
    d = '0;
    for (int n = 0; n < 24 && seen != 4'hF; n++) begin
      @(negedge sys_clk);
      i = cur_idx();
      if (i >= 0) begin
        d[8*i +: 8] = segments;
        seen[i] = 1'b1;
      end
    end
    chk("scan_all_digits", {28'd0, seen}, 32'hF);
  endtask
  task automatic pulse_load(input logic [7:0] v, input logic s);
    value = v;
    signed_mode = s;
    load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
  endtask
  task automatic run_one(input string tag, input logic [7:0] v, input logic s);
    int n;
    logic [31:0] got;
    sb.push_back(exp_disp(v, s));
    pulse_load(v, s);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge sys_clk);
    end
    chk({tag, "_busy_len"}, n, 9);
    read_disp(got);
    chk(tag, got, sb.pop_front());
  endtask
  initial begin
    int nb, ix;
    logic [31:0] got, e10;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    chk("rst_digit", {28'd0, digit}, 32'h1);
    chk("rst_segments", {24'd0, segments}, 32'hC0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge sys_clk);
      if (i % 4 == 0) chk($sformatf("scan_step_%0d", i), {28'd0, digit}, 32'(4'b0001 << ((i / 4) % 4)));
      if (i % 4 == 3) chk($sformatf("scan_hold_%0d", i), {28'd0, digit}, 32'(4'b0001 << ((i / 4) % 4)));
    end
    run_one("u205", 8'd205, 1'b0);
    run_one("s_m128", 8'h80, 1'b1);
    run_one("u128", 8'h80, 1'b0);
    run_one("u7", 8'd7, 1'b0);
    run_one("s_m1", 8'hFF, 1'b1);
    run_one("u0", 8'd0, 1'b0);
    run_one("s_p99", 8'd99, 1'b1);
    // Pending overwrite: 10 at edge 0, 99 at edge 2, 42 at edge 3; 99 must be replaced.
    nb = 0;
    sb.push_back(exp_disp(8'd10, 1'b0));
    value = 8'd10; signed_mode = 1'b0; load = 1'b1;
    @(negedge sys_clk); nb += int'(busy); load = 1'b0;
    @(negedge sys_clk); nb += int'(busy); value = 8'd99; load = 1'b1;
    sb.push_back(exp_disp(8'd99, 1'b0));
    @(negedge sys_clk); nb += int'(busy); value = 8'd42;
    sb[sb.size() - 1] = exp_disp(8'd42, 1'b0);
    @(negedge sys_clk); nb += int'(busy); load = 1'b0;
    for (int e = 4; e < 40; e++) begin
      @(negedge sys_clk);
      nb += int'(busy);
      if (e == 12) begin
        e10 = sb.pop_front();
        ix = cur_idx();
        chk("ovr_first_onehot", {31'd0, ix >= 0}, 32'h1);
        if (ix >= 0) chk("ovr_first_glyph", {24'd0, segments}, {24'd0, e10[8*ix +: 8]});
      end
      if (!busy) break;
    end
    chk("ovr_busy_len", nb, 18);
    read_disp(got);
    chk("ovr_second", got, sb.pop_front());
    chk("ovr_queue_empty", sb.size(), 0);
    // Reset during the 4th SHIFT cycle with a pending request queued.
    sb.push_back(exp_disp(8'd200, 1'b0));
    value = 8'd200; signed_mode = 1'b0; load = 1'b1;
    @(negedge sys_clk); load = 1'b0;
    @(negedge sys_clk); value = 8'd5; load = 1'b1;
    @(negedge sys_clk); load = 1'b0;
    @(negedge sys_clk); rst = 1'b1;
    @(negedge sys_clk); rst = 1'b0;
    sb.delete();
    sb.push_back({8'hFF, 8'hFF, 8'hFF, 8'hC0});
    chk("midrst_busy", {31'd0, busy}, 32'h0);
    chk("midrst_digit", {28'd0, digit}, 32'h1);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      nb += int'(busy);
    end
    chk("midrst_no_resume", nb, 0);
    read_disp(got);
    chk("midrst_display", got, sb.pop_front());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
